udp_echo_app_queued_ctrl: RTL and testbench

Control-path block for the queued UDP echo application. It replaces the single-packet echo controller with one that buffers up to `HDR_Q_DEPTH` received headers and streams payload cut-through from RX to TX. It drives the write and read controls of the header store in the companion datapath. It sits between the UDP RX engine (source) and the UDP TX engine (destination), and keeps per-packet beat and wrap-around packet counters.

---
 rtl/udp_echo_app_queued_ctrl.sv | 138 +++++++++++++
 tb/tb_udp_echo_app_queued_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_echo_app_queued_ctrl.sv
// Control path for the queued UDP echo application: a header queue of HDR_Q_DEPTH entries
// feeding a TX sequencer that streams payload cut-through from RX to TX.
module udp_echo_app_queued_ctrl #(
  parameter int unsigned HDR_Q_DEPTH = 4,
  parameter int unsigned PTR_W       = $clog2(HDR_Q_DEPTH),
  parameter int unsigned BEAT_CNT_W  = 16,
  parameter int unsigned PKT_CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_udp_echo_app_rx_hdr_val,
  output logic                  udp_echo_app_src_rx_hdr_rdy,
  input  logic                  src_udp_echo_app_rx_data_val,
  input  logic                  src_udp_echo_app_rx_last,
  output logic                  udp_echo_app_src_rx_data_rdy,
  output logic                  udp_echo_app_dst_hdr_val,
  input  logic                  dst_udp_echo_app_hdr_rdy,
  output logic                  udp_echo_app_dst_data_val,
  output logic                  udp_echo_app_dst_data_last,
  input  logic                  dst_udp_echo_app_data_rdy,
  output logic                  ctrl_datap_hdr_wr_en,
  output logic [PTR_W-1:0]      ctrl_datap_hdr_wr_ptr,
  output logic [PTR_W-1:0]      ctrl_datap_hdr_rd_ptr,
  output logic [BEAT_CNT_W-1:0] ctrl_datap_beat_cnt,
  output logic [PKT_CNT_W-1:0]  pkt_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [PTR_W:0] LP_DEPTH   = (PTR_W + 1)'(HDR_Q_DEPTH);
  localparam logic [PTR_W:0] LP_OCC_ONE = (PTR_W + 1)'(1);

  logic [1:0]            r_state;
  logic [1:0]            w_state_d;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_occ;
  logic [PTR_W:0]        w_occ_d;
  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic [PKT_CNT_W-1:0]  r_pkt_cnt;

  logic w_in_hdr;
  logic w_in_data;
  logic w_hdr_rdy;
  logic w_push;
  logic w_hdr_hs;
  logic w_data_hs;
  logic w_pop;

  assign w_in_hdr  = (r_state == ST_HDR);
  assign w_in_data = (r_state == ST_DATA);

  // Ready looks only at registered occupancy: a full queue refuses even during a pop.
  assign w_hdr_rdy = (r_occ != LP_DEPTH);
  assign w_push    = src_udp_echo_app_rx_hdr_val & w_hdr_rdy;
  assign w_hdr_hs  = w_in_hdr & dst_udp_echo_app_hdr_rdy;
  assign w_data_hs = w_in_data & src_udp_echo_app_rx_data_val & dst_udp_echo_app_data_rdy;
  assign w_pop     = w_data_hs & src_udp_echo_app_rx_last;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_occ != '0) w_state_d = ST_HDR;
      end
      ST_HDR: begin
        if (dst_udp_echo_app_hdr_rdy) w_state_d = ST_DATA;
      end
      ST_DATA: begin
        // Another header already queued: present it next cycle without an IDLE bubble.
        if (w_pop) w_state_d = (r_occ > LP_OCC_ONE) ? ST_HDR : ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_occ_d = r_occ;
    if (w_push && !w_pop) begin
      w_occ_d = r_occ + LP_OCC_ONE;
    end else if (!w_push && w_pop) begin
      w_occ_d = r_occ - LP_OCC_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_occ   <= '0;
    end else begin
      r_state <= w_state_d;
      r_occ   <= w_occ_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      if (w_hdr_hs) begin
        r_beat_cnt <= '0;
      end else if (w_data_hs && (r_beat_cnt != '1)) begin
        r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
      end
      if (w_pop) r_pkt_cnt <= r_pkt_cnt + PKT_CNT_W'(1);
    end
  end

  assign udp_echo_app_src_rx_hdr_rdy  = w_hdr_rdy;
  assign udp_echo_app_dst_hdr_val     = w_in_hdr;
  assign udp_echo_app_dst_data_val    = w_in_data & src_udp_echo_app_rx_data_val;
  assign udp_echo_app_dst_data_last   = w_in_data & src_udp_echo_app_rx_data_val &
                                        src_udp_echo_app_rx_last;
  assign udp_echo_app_src_rx_data_rdy = w_in_data & dst_udp_echo_app_data_rdy;
  assign ctrl_datap_hdr_wr_en         = w_push;
  assign ctrl_datap_hdr_wr_ptr        = r_wr_ptr;
  assign ctrl_datap_hdr_rd_ptr        = r_rd_ptr;
  assign ctrl_datap_beat_cnt          = r_beat_cnt;
  assign pkt_cnt                      = r_pkt_cnt;

  a_occ_bounded : assert property (@(posedge clk) disable iff (!rst) r_occ <= LP_DEPTH);
  a_hdr_hold : assert property (@(posedge clk) disable iff (!rst)
    (w_in_hdr && !dst_udp_echo_app_hdr_rdy) |=> w_in_hdr);

endmodule

// File: tb/tb_udp_echo_app_queued_ctrl.sv
// Bench for udp_echo_app_queued_ctrl: a reset/single-packet vector table, directed corner
// sequences and randomized traffic, all checked against a queue-based transaction model.
module tb_udp_echo_app_queued_ctrl;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hv = 1'b0, dv = 1'b0, dl = 1'b0, thr = 1'b0, tdr = 1'b0;
  logic        o_hrdy, o_drdy, o_hval, o_dval, o_dlast, o_wen;
  logic [1:0]  o_wp, o_rp;
  logic [15:0] o_beat;
  logic [31:0] o_pkt;

  always #5 clk = ~clk;

  udp_echo_app_queued_ctrl #(.HDR_Q_DEPTH(DEPTH)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .src_udp_echo_app_rx_hdr_val  (hv),
    .udp_echo_app_src_rx_hdr_rdy  (o_hrdy),
    .src_udp_echo_app_rx_data_val (dv),
    .src_udp_echo_app_rx_last     (dl),
    .udp_echo_app_src_rx_data_rdy (o_drdy),
    .udp_echo_app_dst_hdr_val     (o_hval),
    .dst_udp_echo_app_hdr_rdy     (thr),
    .udp_echo_app_dst_data_val    (o_dval),
    .udp_echo_app_dst_data_last   (o_dlast),
    .dst_udp_echo_app_data_rdy    (tdr),
    .ctrl_datap_hdr_wr_en         (o_wen),
    .ctrl_datap_hdr_wr_ptr        (o_wp),
    .ctrl_datap_hdr_rd_ptr        (o_rp),
    .ctrl_datap_beat_cnt          (o_beat),
    .pkt_cnt                      (o_pkt)
  );

  int tests_run = 0;
  int failed    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction model: queued header tags, whether a header is being offered to TX,
  // and whether a packet's payload is currently streaming.
  int m_q[$];
  bit m_offer, m_stream;
  int m_pushes, m_pops, m_beats;
  bit g_push, g_data_hs, prev_pop_obs;
  int b2b_hits, obs_beats;

  // RX source bookkeeping
  int pkt_len[$];
  int d_idx, d_beat;

  task automatic model_reset();
    m_q.delete();
    m_offer = 0; m_stream = 0;
    m_pushes = 0; m_pops = 0; m_beats = 0;
    prev_pop_obs = 0; b2b_hits = 0; obs_beats = 0;
    pkt_len.delete(); d_idx = 0; d_beat = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; hv = 0; dv = 0; dl = 0; thr = 0; tdr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic drive_data(input bit want);
    if (d_idx < pkt_len.size() && d_idx < m_pushes) begin
      dv = want;
      dl = (d_beat == pkt_len[d_idx] - 1);
    end else begin
      dv = 0;
      dl = 0;
    end
  endtask

  // Called at a negedge with inputs applied; checks, advances one clock, returns at negedge.
  task automatic step();
    int  sz;
    bit  hdr_hs, pop, wake, pop_obs;
    #1;
    sz = m_q.size();
    chk("hdr_rdy",   o_hrdy,  sz != DEPTH);
    chk("wr_en",     o_wen,   hv && (sz != DEPTH));
    chk("hdr_val",   o_hval,  m_offer);
    chk("data_val",  o_dval,  m_stream && dv);
    chk("data_last", o_dlast, m_stream && dv && dl);
    chk("data_rdy",  o_drdy,  m_stream && tdr);
    chk("wr_ptr",    o_wp,    m_pushes % DEPTH);
    chk("rd_ptr",    o_rp,    m_pops % DEPTH);
    chk("beat_cnt",  o_beat,  m_beats);
    chk("pkt_cnt",   o_pkt,   m_pops);
    pop_obs = o_dlast && o_drdy;
    if (o_hval && prev_pop_obs) b2b_hits++;
    prev_pop_obs = pop_obs;
    if (dv && o_drdy) obs_beats++;
    g_push    = hv && (sz != DEPTH);
    hdr_hs    = m_offer && thr;
    g_data_hs = m_stream && dv && tdr;
    pop       = g_data_hs && dl;
    wake      = !m_offer && !m_stream && (sz > 0);
    @(posedge clk);
    if (g_data_hs && m_beats < 65535) m_beats++;
    if (hdr_hs) begin
      m_offer = 0; m_stream = 1; m_beats = 0;
    end
    if (pop) begin
      void'(m_q.pop_front());
      m_pops++;
      m_stream = 0;
      m_offer  = (sz > 1);
    end
    if (wake) m_offer = 1;
    if (g_push) begin
      m_q.push_back(m_pushes);
      m_pushes++;
    end
    @(negedge clk);
  endtask

  task automatic post_data();
    if (g_data_hs) begin
      if (dl) begin
        d_idx++;
        d_beat = 0;
      end else begin
        d_beat++;
      end
    end
  endtask

  typedef struct {
    logic hv, dv, dl, thr, tdr;
    logic e_hrdy, e_hval, e_dval, e_dlast, e_drdy, e_wen;
    int   e_wp, e_rp, e_beat, e_pkt;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] ins, input logic [5:0] outs,
                              input int wp, input int rp, input int beat, input int pkt);
    vec_t v;
    {v.hv, v.dv, v.dl, v.thr, v.tdr} = ins;
    {v.e_hrdy, v.e_hval, v.e_dval, v.e_dlast, v.e_drdy, v.e_wen} = outs;
    v.e_wp = wp; v.e_rp = rp; v.e_beat = beat; v.e_pkt = pkt;
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    int   n_pkts, seen;
    logic hold_h, want;

    // Single packet, 3 beats, both sides ready; RX data offered early must be held.
    vecs[0] = mk(5'b10011, 6'b100001, 0, 0, 0, 0);
    vecs[1] = mk(5'b01011, 6'b100000, 1, 0, 0, 0);
    vecs[2] = mk(5'b01011, 6'b110000, 1, 0, 0, 0);
    vecs[3] = mk(5'b01011, 6'b101010, 1, 0, 0, 0);
    vecs[4] = mk(5'b01011, 6'b101010, 1, 0, 1, 0);
    vecs[5] = mk(5'b01111, 6'b101110, 1, 0, 2, 0);
    vecs[6] = mk(5'b00011, 6'b100000, 1, 1, 3, 1);

    // Reset values
    @(negedge clk);
    #1;
    chk("rst_hdr_rdy", o_hrdy, 1); chk("rst_hdr_val", o_hval, 0);
    chk("rst_data_val", o_dval, 0); chk("rst_data_last", o_dlast, 0);
    chk("rst_data_rdy", o_drdy, 0); chk("rst_wr_en", o_wen, 0);
    chk("rst_ptrs", {o_wp, o_rp}, 0); chk("rst_beat", o_beat, 0); chk("rst_pkt", o_pkt, 0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      {hv, dv, dl, thr, tdr} = {vecs[i].hv, vecs[i].dv, vecs[i].dl, vecs[i].thr, vecs[i].tdr};
      #1;
      chk($sformatf("vec%0d_hdr_rdy", i),   o_hrdy,  vecs[i].e_hrdy);
      chk($sformatf("vec%0d_hdr_val", i),   o_hval,  vecs[i].e_hval);
      chk($sformatf("vec%0d_data_val", i),  o_dval,  vecs[i].e_dval);
      chk($sformatf("vec%0d_data_last", i), o_dlast, vecs[i].e_dlast);
      chk($sformatf("vec%0d_data_rdy", i),  o_drdy,  vecs[i].e_drdy);
      chk($sformatf("vec%0d_wr_en", i),     o_wen,   vecs[i].e_wen);
      chk($sformatf("vec%0d_wr_ptr", i),    o_wp,    vecs[i].e_wp);
      chk($sformatf("vec%0d_rd_ptr", i),    o_rp,    vecs[i].e_rp);
      chk($sformatf("vec%0d_beat", i),      o_beat,  vecs[i].e_beat);
      chk($sformatf("vec%0d_pkt", i),       o_pkt,   vecs[i].e_pkt);
      @(posedge clk);
      @(negedge clk);
    end

    // Back-to-back: four 2-beat packets, headers in consecutive cycles
    do_reset();
    pkt_len = '{2, 2, 2, 2};
    for (int c = 0; c < 30; c++) begin
      hv = (c < 4); thr = 1; tdr = 1;
      drive_data(1);
      step();
      post_data();
    end
    chk("b2b_wr_ptr_wrap", o_wp, 0);
    chk("b2b_pkt_cnt", o_pkt, 4);
    chk("b2b_no_bubble", b2b_hits, 3);

    // Full queue, then pops at full occupancy with a fifth header pending
    do_reset();
    pkt_len = '{2, 1, 1, 1, 1};
    for (int c = 0; c < 8; c++) begin
      hv = (m_pushes < 5); thr = 0; tdr = 1;
      drive_data(1);
      step();
      post_data();
    end
    chk("full_hdr_rdy", o_hrdy, 0);
    chk("full_data_rdy", o_drdy, 0);
    chk("full_wr_ptr", o_wp, 0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      hv = (m_pushes < 5); thr = 1; tdr = 1;
      drive_data(1);
      if (m_stream && dv && dl && m_q.size() == DEPTH) begin
        #1;
        chk("pushpop_hdr_rdy", o_hrdy, 0);
        seen++;
      end
      step();
      post_data();
    end
    chk("pushpop_seen", seen != 0, 1);
    chk("full_pkt_cnt", o_pkt, 5);

    // Backpressure: TX data ready toggles every cycle during a 5-beat packet
    do_reset();
    pkt_len = '{5};
    for (int c = 0; c < 40 && d_idx < 1; c++) begin
      hv = (c == 0); thr = 1; tdr = c[0];
      drive_data(1);
      step();
      post_data();
    end
    chk("bp_done", d_idx, 1);
    chk("bp_beats", obs_beats, 5);
    chk("bp_beat_cnt", o_beat, 5);
    chk("bp_pkt_cnt", o_pkt, 1);

    // Reset mid-packet after 2 of 4 beats, then a fresh packet
    do_reset();
    pkt_len = '{4, 3};
    for (int c = 0; c < 20 && !(d_idx == 0 && d_beat == 2); c++) begin
      hv = (c < 2); thr = 1; tdr = 1;
      drive_data(1);
      step();
      post_data();
    end
    chk("mid_reached", d_beat, 2);
    hv = 0;
    drive_data(1);
    rst = 1'b0;
    #1;
    chk("mid_hdr_rdy", o_hrdy, 1); chk("mid_hdr_val", o_hval, 0);
    chk("mid_data_val", o_dval, 0); chk("mid_data_last", o_dlast, 0);
    chk("mid_data_rdy", o_drdy, 0); chk("mid_wr_en", o_wen, 0);
    chk("mid_ptrs", {o_wp, o_rp}, 0); chk("mid_beat", o_beat, 0); chk("mid_pkt", o_pkt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    pkt_len = '{3};
    for (int c = 0; c < 20; c++) begin
      hv = (c == 0); thr = 1; tdr = 1;
      drive_data(1);
      step();
      post_data();
    end
    chk("mid_after_pkt", o_pkt, 1);
    chk("mid_after_beat", o_beat, 3);

    // Randomized traffic
    do_reset();
    n_pkts = 60;
    for (int i = 0; i < n_pkts; i++) pkt_len.push_back(int'($urandom_range(1, 6)));
    hold_h = 0;
    for (int c = 0; c < 3000; c++) begin
      hv   = (m_pushes < n_pkts) && (hold_h || ($urandom_range(0, 2) != 0));
      want = (dv && !g_data_hs) || ($urandom_range(0, 3) != 0);
      thr  = ($urandom_range(0, 9) < 7);
      tdr  = ($urandom_range(0, 9) < 7);
      drive_data(want);
      step();
      hold_h = hv && !g_push;
      post_data();
    end
    chk("rand_pkts_done", o_pkt, n_pkts);
    chk("rand_wr_ptr", o_wp, n_pkts % DEPTH);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
